mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and 2-way arbiter that shares the single-ported unified instruction/data memory (byte-addressed, 32-bit little-endian words, combinational read, write on posedge clk) between the instruction-fetch port and the load/store port of the multicycle datapath. It runs each access as a fixed-length transaction and drives the memory strobes. It returns read data and a one-cycle acknowledge to the winning requester, and rejects misaligned or out-of-range addresses without touching memory.

## Interface

Parameters:
- WAIT_CYCLES, 0, extra ACCESS cycles per transaction (slow-memory model), 0..15
- MEM_BYTES, 65536, memory size in bytes; the highest legal word address is MEM_BYTES-4

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level signal, held until if_ack
- if_adr  in  32  fetch byte address; stable while if_req=1
- if_rdata  out  32  fetched word; registered
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  valid with if_ack; address was rejected
- d_req  in  1  data request; level signal, held until d_ack
- d_wr  in  1  1=store, 0=load; stable while d_req=1
- d_adr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  loaded word; registered
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  valid with d_ack
- mem_adr  out  32  memory address
- mem_d_in  out  32  memory write data
- mem_mrd  out  1  memory read enable
- mem_mwr  out  1  memory write enable
- mem_d_out  in  32  memory read data

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no request is pending, stay in IDLE. If exactly one request is pending, grant it. If both are pending, grant the port not granted last (round-robin). The last_grant register resets to DATA, so the first tie goes to fetch.
- An address is rejected when adr[1:0]≠0 or adr>MEM_BYTES-4. A rejected grant goes IDLE→RESP directly. No memory strobe is asserted. The port returns rdata=0, err=1.
- A legal grant goes IDLE→ACCESS and loads the wait counter with WAIT_CYCLES.
- ACCESS: mem_adr equals the granted address. For a load or fetch, mem_mrd=1 for all ACCESS cycles. For a store, mem_mwr=1 only in the final ACCESS cycle (counter=0), so exactly one memory write occurs, and mem_d_in=d_wdata. On the final ACCESS edge, the granted port's rdata register captures mem_d_out; stores leave rdata unchanged. The counter decrements each cycle, and the FSM moves to RESP when the counter is 0.
- RESP: the granted port gets ack=1 (and err if rejected) for exactly one cycle. last_grant is updated. The FSM then goes to IDLE.
- Outside ACCESS: mem_mrd=mem_mwr=0 and mem_adr=mem_d_in=0.
- rdata holds its value until that port's next successful load or fetch.
- A requester may keep req high after ack to issue its next transaction; it is re-arbitrated in IDLE.

## Timing

- Reset values: all outputs 0, state IDLE, counter 0, last_grant=DATA. Reset mid-ACCESS drops mem_mwr immediately (asynchronously), so a store aborted before its write edge writes nothing. No ack is issued for the aborted transaction.
- Legal access, request sampled in IDLE at edge 0: ACCESS during cycles 1..1+WAIT_CYCLES, ack in cycle 2+WAIT_CYCLES. Latency is 2+WAIT_CYCLES cycles; throughput is one transaction per 3+WAIT_CYCLES cycles.
- Rejected access: ack+err in cycle 1.
- A request arriving during ACCESS or RESP waits for IDLE. A req that drops before ack is a protocol violation and needs no defined behaviour.

## Structure

- Package mem_arb_pkg: state enum {IDLE, ACCESS, RESP}, grant enum {GNT_IF, GNT_D}, WORD_BYTES=4.
- Sub-module rr_arb2: combinational 2-way round-robin grant from (if_req, d_req, last_grant), 1-hot output. The FSM, counter, and registers stay in the top module.

## Test plan

- Fetch only, WAIT_CYCLES=0, if_adr=0x0, memory word 0x00A1B2C3 → mem_mrd high for 1 cycle; if_ack in cycle 2; if_rdata=0x00A1B2C3; if_err=0.
- Store d_adr=2000, d_wdata=0xFFFFFFF6, then load 2000, WAIT_CYCLES=2 → mem_mwr high for exactly 1 cycle; load d_rdata=0xFFFFFFF6 (-10); d_ack 4 cycles after each request.
- Both ports requesting continuously from reset → grants alternate IF, D, IF, D; no ack overlap; acks 3 cycles apart.
- d_adr=1002 (misaligned) and d_adr=65533 (out of range) → d_ack+d_err one cycle after request; d_rdata=0; mem_mrd=mem_mwr=0 throughout.
- Reset asserted in the first ACCESS cycle of a store with WAIT_CYCLES=1 → memory word unchanged; all outputs 0 immediately; after release, idle until the next request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_D} grant_t;

    localparam int WORD_BYTES = 4;

    // Word-aligned and inside memory; lim is the highest legal word address.
    function automatic logic adr_ok(input logic [31:0] adr, input logic [31:0] lim);
        return (adr[1:0] == 2'b00) && (adr <= lim);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, one-hot: bit 0 = fetch, bit 1 = data.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  grant_t     last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (if_req && d_req)
            gnt = (last_grant == GNT_D) ? 2'b01 : 2'b10;
        else if (if_req)
            gnt = 2'b01;
        else if (d_req)
            gnt = 2'b10;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// running each access as a fixed-length IDLE/ACCESS/RESP transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int MEM_BYTES   = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_d_in,
    output logic        mem_mrd,
    output logic        mem_mwr,
    input  logic [31:0] mem_d_out
);

    localparam logic [31:0] ADR_LIM = 32'(MEM_BYTES - WORD_BYTES);

    state_t      state;
    logic [3:0]  cnt;
    grant_t      gnt_q;
    grant_t      last_grant;
    logic        rej_q;
    logic [1:0]  gnt;

    rr_arb2 u_arb (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    grant_t      gnt_next;
    logic [31:0] req_adr;
    logic [31:0] cur_adr;
    logic        req_legal;
    logic        is_store;
    logic        in_acc;

    assign gnt_next  = gnt[1] ? GNT_D : GNT_IF;
    assign req_adr   = (gnt_next == GNT_D) ? d_adr : if_adr;
    assign req_legal = adr_ok(req_adr, ADR_LIM);
    assign cur_adr   = (gnt_q == GNT_D) ? d_adr : if_adr;
    assign is_store  = (gnt_q == GNT_D) && d_wr;
    assign in_acc    = (state == ACCESS);

    // Strobes decode straight from state so reset kills a pending write at once.
    assign mem_adr  = in_acc ? cur_adr : 32'h0;
    assign mem_d_in = (in_acc && is_store) ? d_wdata : 32'h0;
    assign mem_mrd  = in_acc && !is_store;
    assign mem_mwr  = in_acc && is_store && (cnt == 4'd0);

    assign if_ack = (state == RESP) && (gnt_q == GNT_IF);
    assign d_ack  = (state == RESP) && (gnt_q == GNT_D);
    assign if_err = if_ack && rej_q;
    assign d_err  = d_ack && rej_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            gnt_q      <= GNT_IF;
            last_grant <= GNT_D;
            rej_q      <= 1'b0;
            if_rdata   <= 32'h0;
            d_rdata    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        gnt_q <= gnt_next;
                        rej_q <= !req_legal;
                        if (req_legal) begin
                            state <= ACCESS;
                            cnt   <= 4'(WAIT_CYCLES);
                        end else begin
                            state <= RESP;
                            if (gnt_next == GNT_IF) if_rdata <= 32'h0;
                            else                    d_rdata  <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        if (!is_store) begin
                            if (gnt_q == GNT_IF) if_rdata <= mem_d_out;
                            else                 d_rdata  <= mem_d_out;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    last_grant <= gnt_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory, WAIT_CYCLES=2.
module tb_mem_port_arbiter;

    localparam int W   = 2;
    localparam int LAT = 2 + W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_adr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ack, if_err;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_adr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ack, d_err;
    logic [31:0] mem_adr, mem_d_in, mem_d_out;
    logic        mem_mrd, mem_mwr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_idx = '0;
    logic [31:0] pl_dat = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(W), .MEM_BYTES(65536)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_wr(d_wr), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_adr(mem_adr), .mem_d_in(mem_d_in), .mem_mrd(mem_mrd), .mem_mwr(mem_mwr),
        .mem_d_out(mem_d_out)
    );

    assign mem_d_out = mem[mem_adr[15:2]];

    always @(posedge clk) begin
        if (mem_mwr)    mem[mem_adr[15:2]] <= mem_d_in;
        else if (pl_en) mem[pl_idx] <= pl_dat;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [13:0] idx, input logic [31:0] dat);
        pl_idx = idx; pl_dat = dat; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic logic [159:0] all_out();
        return {26'h0, if_rdata, d_rdata, mem_adr, mem_d_in,
                if_ack, if_err, d_ack, d_err, mem_mrd, mem_mwr};
    endfunction

    // Results of the most recent transaction.
    int          t_cyc, t_rd, t_wr;
    logic [31:0] t_adr, t_wd;
    logic        t_err, t_aif, t_ad;

    task automatic txn(input bit dport, input bit wr, input logic [31:0] adr, input logic [31:0] wd);
        t_cyc = 0; t_rd = 0; t_wr = 0; t_adr = 'x; t_wd = 'x;
        t_err = 1'bx; t_aif = 1'b0; t_ad = 1'b0;
        if (dport) begin d_req = 1'b1; d_wr = wr; d_adr = adr; d_wdata = wd; end
        else       begin if_req = 1'b1; if_adr = adr; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            t_rd += int'(mem_mrd);
            t_wr += int'(mem_mwr);
            if (mem_mrd || mem_mwr) t_adr = mem_adr;
            if (mem_mwr) t_wd = mem_d_in;
            if (if_ack || d_ack) begin
                t_cyc = c; t_aif = if_ack; t_ad = d_ack;
                t_err = dport ? d_err : if_err;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n_ack, last_c;
        bit exp_d;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_out(), 160'h0);
        preload(14'd0, 32'h00A1B2C3);
        preload(14'd16383, 32'h12345678);
        rst = 1'b1;
        @(negedge clk);

        // Fetch from address 0
        txn(1'b0, 1'b0, 32'd0, 32'h0);
        chk("fetch_latency", 160'(t_cyc), 160'(LAT));
        chk("fetch_mrd_cycles", 160'(t_rd), 160'(W + 1));
        chk("fetch_no_write", 160'(t_wr), 160'd0);
        chk("fetch_adr", 160'(t_adr), 160'd0);
        chk("fetch_ack_port", {t_aif, t_ad, t_err}, 160'b100);
        chk("fetch_rdata", 160'(if_rdata), 160'h00A1B2C3);

        // Rejected addresses: misaligned, past the end, just past the last word
        txn(1'b1, 1'b0, 32'd1002, 32'h0);
        chk("misalign_latency", 160'(t_cyc), 160'd1);
        chk("misalign_ack_err", {t_aif, t_ad, t_err}, 160'b011);
        chk("misalign_no_mem", 160'(t_rd + t_wr), 160'd0);
        chk("misalign_rdata", 160'(d_rdata), 160'd0);
        txn(1'b1, 1'b1, 32'd65533, 32'hDEADBEEF);
        chk("oor_store_latency", 160'(t_cyc), 160'd1);
        chk("oor_store_err", {t_ad, t_err}, 160'b11);
        chk("oor_store_no_mem", 160'(t_rd + t_wr), 160'd0);
        txn(1'b1, 1'b0, 32'd65536, 32'h0);
        chk("oor_65536_err", {t_cyc[3:0], t_ad, t_err}, {154'h0, 4'd1, 2'b11});

        // Store then load back
        txn(1'b1, 1'b1, 32'd2000, 32'hFFFFFFF6);
        chk("store_latency", 160'(t_cyc), 160'(LAT));
        chk("store_one_write", 160'(t_wr), 160'd1);
        chk("store_no_read", 160'(t_rd), 160'd0);
        chk("store_adr_data", {t_adr, t_wd}, {32'd2000, 32'hFFFFFFF6});
        chk("store_ack", {t_aif, t_ad, t_err}, 160'b010);
        chk("store_mem", 160'(mem[500]), 160'hFFFFFFF6);
        chk("store_rdata_kept", 160'(d_rdata), 160'd0);
        txn(1'b1, 1'b0, 32'd2000, 32'h0);
        chk("load_latency", 160'(t_cyc), 160'(LAT));
        chk("load_rdata", 160'(d_rdata), 160'hFFFFFFF6);
        chk("load_if_rdata_kept", 160'(if_rdata), 160'h00A1B2C3);

        // Highest legal word
        txn(1'b1, 1'b0, 32'd65532, 32'h0);
        chk("top_word_latency", 160'(t_cyc), 160'(LAT));
        chk("top_word_ok", {t_ad, t_err}, 160'b10);
        chk("top_word_rdata", 160'(d_rdata), 160'h12345678);

        // Round-robin from reset with both ports requesting continuously
        rst = 1'b0;
        preload(14'd1, 32'h11110001);
        preload(14'd2, 32'h22220002);
        rst = 1'b1;
        if_adr = 32'd4; d_adr = 32'd8; d_wr = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        n_ack = 0; last_c = 0; exp_d = 1'b0;
        for (int c = 1; c <= 40 && n_ack < 4; c++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                chk("rr_no_overlap", 160'(if_ack & d_ack), 160'd0);
                chk("rr_port", 160'(d_ack), 160'(exp_d));
                chk("rr_spacing", 160'(c - last_c), (n_ack == 0) ? 160'(LAT) : 160'(LAT + 1));
                last_c = c; exp_d = !exp_d; n_ack++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("rr_ack_count", 160'(n_ack), 160'd4);
        chk("rr_rdata", {if_rdata, d_rdata}, {32'h11110001, 32'h22220002});
        repeat (2) @(negedge clk);

        // Reset during the first ACCESS cycle of a store
        preload(14'd600, 32'hCAFEF00D);
        d_req = 1'b1; d_wr = 1'b1; d_adr = 32'd2400; d_wdata = 32'h11111111;
        @(negedge clk);
        chk("abort_in_access", {mem_adr, mem_mwr}, {32'd2400, 1'b0});
        rst = 1'b0;
        #1;
        chk("abort_outputs_zero", all_out(), 160'h0);
        @(negedge clk);
        d_req = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_idle", {if_ack, d_ack, mem_mrd, mem_mwr}, 160'd0);
        end
        chk("abort_mem_kept", 160'(mem[600]), 160'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
